// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StLink,
    StBranch
  } mc_state_t;

  typedef enum logic [1:0] {
    SrcBRd2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResData      = 2'b01,
    ResAluResult = 2'b10,
    ResPc        = 2'b11
  } result_src_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       bl;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode from FSM state; reset shows FETCH selects
// with every enable held low.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] FETCH_PC_SEL = 2'b10
) (
  input  mc_state_t  state,
  input  logic       mem_ready,
  input  logic       reset,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl            = '0;
    ctrl.alu_src_b  = SrcBRd2;
    ctrl.result_src = ResAluOut;
    if (reset) begin
      ctrl.alu_src_a  = 1'b1;
      ctrl.alu_src_b  = SrcBFour;
      ctrl.result_src = FETCH_PC_SEL;
    end else begin
      unique case (state)
        StFetch: begin
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SrcBFour;
          ctrl.result_src = FETCH_PC_SEL;
          ctrl.ir_write   = mem_ready;
          ctrl.next_pc    = mem_ready;
        end
        // PC+8 so that R15 reads see the architectural value
        StDecode: begin
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = SrcBFour;
          ctrl.result_src = ResAluResult;
        end
        StMemAdr: ctrl.alu_src_b = SrcBImm;
        StMemRd:  ctrl.adr_src = 1'b1;
        StMemWr: begin
          ctrl.adr_src = 1'b1;
          ctrl.mem_w   = 1'b1;
        end
        StMemWb: begin
          ctrl.result_src = ResData;
          ctrl.reg_w      = 1'b1;
        end
        StExecR: ctrl.alu_op = 1'b1;
        StExecI: begin
          ctrl.alu_src_b = SrcBImm;
          ctrl.alu_op    = 1'b1;
        end
        StAluWb: ctrl.reg_w = 1'b1;
        StLink: begin
          ctrl.result_src = ResPc;
          ctrl.reg_w      = 1'b1;
          ctrl.bl         = 1'b1;
        end
        StBranch: begin
          ctrl.alu_src_b  = SrcBImm;
          ctrl.result_src = ResAluResult;
          ctrl.branch     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM for the multicycle ARM datapath: state register,
// next-state logic and the illegal-opcode pulse.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [1:0] FETCH_PC_SEL = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       BL,
  output logic       illegal
);

  mc_state_t  state_q;
  ctrl_word_t ctrl;

  // Funct[3:1] belong to the ALU decoder, not to sequencing
  logic unused_funct;
  assign unused_funct = ^Funct[3:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  if (mem_ready) state_q <= StDecode;
        StDecode: begin
          case (Op)
            OP_MEM:  state_q <= StMemAdr;
            OP_DP:   state_q <= Funct[5] ? StExecI : StExecR;
            OP_BR:   state_q <= Funct[4] ? StLink : StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= Funct[0] ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state_q <= StMemWb;
        StMemWr:  if (mem_ready) state_q <= StFetch;
        StExecR,
        StExecI:  state_q <= StAluWb;
        StLink:   state_q <= StBranch;
        default:  state_q <= StFetch;
      endcase
    end
  end

  mc_ctrl_outdec #(
    .FETCH_PC_SEL(FETCH_PC_SEL)
  ) u_outdec (
    .state    (state_q),
    .mem_ready(mem_ready),
    .reset    (reset),
    .ctrl     (ctrl)
  );

  assign IRWrite   = ctrl.ir_write;
  assign NextPC    = ctrl.next_pc;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign BL        = ctrl.bl;
  assign illegal   = !reset && (state_q == StDecode) && (Op == 2'b11);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle state and control-word checks.
module tb_multicycle_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, BL, illegal;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [13:0] obs;

  int total = 0;
  int bad   = 0;

  // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,BL,illegal}
  localparam logic [13:0] VF1  = 14'b11_0_1_10_10_000000;
  localparam logic [13:0] VF0  = 14'b00_0_1_10_10_000000;
  localparam logic [13:0] VRST = 14'b00_0_1_10_10_000000;
  localparam logic [13:0] VDEC = 14'b00_0_1_10_10_000000;
  localparam logic [13:0] VDIL = 14'b00_0_1_10_10_000001;
  localparam logic [13:0] VMAD = 14'b00_0_0_01_00_000000;
  localparam logic [13:0] VMRD = 14'b00_1_0_00_00_000000;
  localparam logic [13:0] VMWR = 14'b00_1_0_00_00_001000;
  localparam logic [13:0] VMWB = 14'b00_0_0_00_01_010000;
  localparam logic [13:0] VEXR = 14'b00_0_0_00_00_100000;
  localparam logic [13:0] VEXI = 14'b00_0_0_01_00_100000;
  localparam logic [13:0] VAWB = 14'b00_0_0_00_00_010000;
  localparam logic [13:0] VLNK = 14'b00_0_0_00_11_010010;
  localparam logic [13:0] VBR  = 14'b00_0_0_01_10_000100;

  multicycle_ctrl_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Funct    (Funct),
    .mem_ready(mem_ready),
    .IRWrite  (IRWrite),
    .NextPC   (NextPC),
    .AdrSrc   (AdrSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ResultSrc(ResultSrc),
    .ALUOp    (ALUOp),
    .RegW     (RegW),
    .MemW     (MemW),
    .Branch   (Branch),
    .BL       (BL),
    .illegal  (illegal)
  );

  assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUOp, RegW, MemW, Branch, BL, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (dut.state_q !== StFetch) begin
        bad++;
        $display("FAIL reset_state cyc%0d got=%0d want=%0d", i, dut.state_q, StFetch);
      end
      total++;
      if (obs !== VRST) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d got=%b want=%b", i, obs, VRST);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== VF0) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", obs, VF0);
    end
  endtask

  task automatic test_dp_reg();
    mc_state_t   es[5] = '{StFetch, StDecode, StExecR, StAluWb, StFetch};
    logic [13:0] eo[5] = '{VF1, VDEC, VEXR, VAWB, VF0};
    logic        rd[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 2'b00;
    Funct = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL dp_reg_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL dp_reg_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_dp_imm();
    mc_state_t   es[5] = '{StFetch, StDecode, StExecI, StAluWb, StFetch};
    logic [13:0] eo[5] = '{VF1, VDEC, VEXI, VAWB, VF0};
    logic        rd[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    Op = 2'b00;
    Funct = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL dp_imm_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL dp_imm_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_ldr_stall();
    mc_state_t   es[8] = '{StFetch, StDecode, StMemAdr, StMemRd, StMemRd, StMemRd,
                           StMemWb, StFetch};
    logic [13:0] eo[8] = '{VF1, VDEC, VMAD, VMRD, VMRD, VMRD, VMWB, VF0};
    logic        rd[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Op = 2'b01;
    Funct = 6'b011001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL ldr_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL ldr_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_str_stall();
    mc_state_t   es[6] = '{StFetch, StDecode, StMemAdr, StMemWr, StMemWr, StFetch};
    logic [13:0] eo[6] = '{VF1, VDEC, VMAD, VMWR, VMWR, VF0};
    logic        rd[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    Op = 2'b01;
    Funct = 6'b011000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL str_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL str_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_branch_link();
    mc_state_t   es[9] = '{StFetch, StDecode, StLink, StBranch,
                           StFetch, StDecode, StBranch, StFetch, StFetch};
    logic [13:0] eo[9] = '{VF1, VDEC, VLNK, VBR, VF1, VDEC, VBR, VF0, VF0};
    logic        rd[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0]  fn[9] = '{6'b110000, 6'b110000, 6'b110000, 6'b110000,
                           6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000};
    Op = 2'b10;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      Funct = fn[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL branch_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL branch_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_fetch_stall_illegal();
    mc_state_t   es[6] = '{StFetch, StFetch, StFetch, StFetch, StDecode, StFetch};
    logic [13:0] eo[6] = '{VF0, VF0, VF0, VF1, VDIL, VF0};
    logic        rd[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Op = 2'b11;
    Funct = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL fetch_illegal_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL fetch_illegal_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    mc_state_t   es[9] = '{StFetch, StDecode, StMemAdr, StMemWr, StMemWr, StFetch,
                           StDecode, StFetch, StFetch};
    logic [13:0] eo[9] = '{VF1, VDEC, VMAD, VMWR, VRST, VF1, VRST, VF0, VF0};
    logic        rd[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        rs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  op[9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    Funct = 6'b011000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_ready = rd[i];
      reset = rs[i];
      Op = op[i];
      #1;
      total++;
      if (dut.state_q !== es[i]) begin
        bad++;
        $display("FAIL reset_abort_state cyc%0d got=%0d want=%0d", i, dut.state_q, es[i]);
      end
      total++;
      if (obs !== eo[i]) begin
        bad++;
        $display("FAIL reset_abort_out cyc%0d got=%b want=%b", i, obs, eo[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    Op = 2'b00;
    Funct = 6'b000000;
    test_reset();
    test_dp_reg();
    test_dp_imm();
    test_ldr_stall();
    test_str_stall();
    test_branch_link();
    test_fetch_stall_illegal();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
